// File: rtl/time_set_ctrl.sv
// time_set_ctrl: HH:MM:SS keeper with a RUN -> SET_HOUR -> SET_MIN mode FSM and set-mode digit blink.
// Define AUTO_REPEAT_EN to add hold-to-repeat on btnInc while in the set modes.
module time_set_ctrl #(
  parameter int HOUR_MAX  = 23,
  parameter int MIN_MAX   = 59,
  parameter int SEC_MAX   = 59,
  parameter int BLINK_DIV = 50
`ifdef AUTO_REPEAT_EN
  ,
  parameter int HOLD_TICKS = 50,
  parameter int RPT_TICKS  = 10
`endif
) (
  input  logic       clkIn,
  input  logic       rstN,
  input  logic       tick1Hz,
  input  logic       tickSlow,
  input  logic       btnMode,
  input  logic       btnInc,
  output logic       divEn,
  output logic [1:0] mode,
  output logic [4:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic       blankHour,
  output logic       blankMin,
  output logic       dayWrap
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2
  } state_t;

  localparam int BLINK_W = $clog2(BLINK_DIV + 1);
  localparam logic [4:0] HOUR_LAST = 5'(HOUR_MAX);
  localparam logic [5:0] MIN_LAST  = 6'(MIN_MAX);
  localparam logic [5:0] SEC_LAST  = 6'(SEC_MAX);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  state_t state;
  state_t next_state;
  logic mode_prev;
  logic inc_prev;
  logic press_mode;
  logic press_inc;
  logic rpt_fire;
  logic state_change;
  logic inc_event;
  logic [BLINK_W-1:0] blink_cnt;
  logic [BLINK_W-1:0] blink_cnt_next;
  logic phase;
  logic phase_next;

  assign press_mode   = btnMode & ~mode_prev;
  assign press_inc    = btnInc & ~inc_prev;
  assign state_change = (next_state != state);
  // A mode press on the same cycle swallows any increment
  assign inc_event    = (press_inc | rpt_fire) & ~press_mode;
  assign divEn        = (state == RUN);
  assign mode         = state;

  always_comb begin
    next_state = state;
    case (state)
      RUN:      if (press_mode) next_state = SET_HOUR;
      SET_HOUR: if (press_mode) next_state = SET_MIN;
      SET_MIN:  if (press_mode) next_state = RUN;
      default:  next_state = RUN;
    endcase
  end

  always_comb begin
    blink_cnt_next = blink_cnt;
    phase_next     = phase;
    if (state_change || press_inc || rpt_fire) begin
      blink_cnt_next = '0;
      phase_next     = 1'b0;
    end else if (tickSlow) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt_next = '0;
        phase_next     = ~phase;
      end else begin
        blink_cnt_next = blink_cnt + 1'b1;
      end
    end
  end

`ifdef AUTO_REPEAT_EN
  localparam int HOLD_W = $clog2(HOLD_TICKS + RPT_TICKS + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(HOLD_TICKS - 1);
  localparam logic [HOLD_W-1:0] RPT_LAST    = HOLD_W'(HOLD_TICKS + RPT_TICKS - 1);
  localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(HOLD_TICKS);

  logic [HOLD_W-1:0] hold_cnt;
  logic hold_armed;
  logic in_set;

  assign in_set   = (state == SET_HOUR) || (state == SET_MIN);
  assign rpt_fire = in_set & hold_armed & btnInc & tickSlow &
                    ((hold_cnt == HOLD_LAST) | (hold_cnt == RPT_LAST));

  // After the first repeat the counter reloads so later repeats come every RPT_TICKS
  always_ff @(posedge clkIn) begin
    if (!rstN) begin
      hold_armed <= 1'b0;
      hold_cnt   <= '0;
    end else if (state_change || !btnInc || !in_set) begin
      hold_armed <= 1'b0;
      hold_cnt   <= '0;
    end else if (press_inc) begin
      hold_armed <= 1'b1;
      hold_cnt   <= '0;
    end else if (hold_armed && tickSlow) begin
      hold_cnt <= rpt_fire ? HOLD_RELOAD : hold_cnt + 1'b1;
    end
  end
`else
  assign rpt_fire = 1'b0;
`endif

  always_ff @(posedge clkIn) begin
    if (!rstN) begin
      state     <= RUN;
      mode_prev <= 1'b1;
      inc_prev  <= 1'b1;
      hours     <= '0;
      minutes   <= '0;
      seconds   <= '0;
      blink_cnt <= '0;
      phase     <= 1'b0;
      blankHour <= 1'b0;
      blankMin  <= 1'b0;
      dayWrap   <= 1'b0;
    end else begin
      state     <= next_state;
      mode_prev <= btnMode;
      inc_prev  <= btnInc;
      blink_cnt <= blink_cnt_next;
      phase     <= phase_next;
      blankHour <= (next_state == SET_HOUR) & phase_next;
      blankMin  <= (next_state == SET_MIN) & phase_next;
      dayWrap   <= 1'b0;
      case (state)
        RUN: begin
          if (tick1Hz) begin
            if (seconds != SEC_LAST) begin
              seconds <= seconds + 1'b1;
            end else begin
              seconds <= '0;
              if (minutes != MIN_LAST) begin
                minutes <= minutes + 1'b1;
              end else begin
                minutes <= '0;
                if (hours != HOUR_LAST) begin
                  hours <= hours + 1'b1;
                end else begin
                  hours   <= '0;
                  dayWrap <= 1'b1;
                end
              end
            end
          end
        end
        SET_HOUR: begin
          if (inc_event) hours <= (hours == HOUR_LAST) ? '0 : hours + 1'b1;
        end
        SET_MIN: begin
          if (inc_event) minutes <= (minutes == MIN_LAST) ? '0 : minutes + 1'b1;
          // Leaving set mode restarts the minute cleanly
          if (press_mode) seconds <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Randomized and directed bench for time_set_ctrl against a seconds-of-day behavioural model.
`timescale 1ns/1ps
module tb_time_set_ctrl;

  localparam int HOLD = 50;
  localparam int RPT  = 10;
  localparam int BLINK = 50;

  logic clkIn = 1'b0;
  logic rstN, tick1Hz, tickSlow, btnMode, btnInc;
  logic divEn, blankHour, blankMin, dayWrap;
  logic [1:0] mode;
  logic [4:0] hours;
  logic [5:0] minutes, seconds;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  int m_mode, m_time, m_ticks, m_held;
  bit m_day, m_prev_mode, m_prev_inc, m_armed;

  always #5 clkIn = ~clkIn;

  time_set_ctrl dut (
    .clkIn(clkIn), .rstN(rstN), .tick1Hz(tick1Hz), .tickSlow(tickSlow),
    .btnMode(btnMode), .btnInc(btnInc), .divEn(divEn), .mode(mode),
    .hours(hours), .minutes(minutes), .seconds(seconds),
    .blankHour(blankHour), .blankMin(blankMin), .dayWrap(dayWrap)
  );

  task automatic check_value(string name, int actual, int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Model keeps time as seconds-of-day and blink as tickSlow pulses since the last clear
  task automatic model_update(bit rst_n, bit bm, bit bi, bit t1, bit ts);
    bit pm, pi, fire;
    int old_mode, h, mi, s;
    if (!rst_n) begin
      m_mode = 0; m_time = 0; m_ticks = 0; m_day = 0;
      m_prev_mode = 1; m_prev_inc = 1; m_armed = 0; m_held = 0;
      return;
    end
    pm = bm && !m_prev_mode;
    pi = bi && !m_prev_inc;
    fire = 0;
    old_mode = m_mode;
`ifdef AUTO_REPEAT_EN
    if (pm || !bi || old_mode == 0) begin
      m_armed = 0; m_held = 0;
    end else if (pi) begin
      m_armed = 1; m_held = 0;
    end else if (m_armed && ts) begin
      m_held++;
      fire = (m_held >= HOLD) && ((m_held - HOLD) % RPT == 0);
    end
`endif
    m_day = 0;
    if (old_mode == 0 && t1) begin
      m_time = (m_time + 1) % 86400;
      m_day = (m_time == 0);
    end
    h = m_time / 3600; mi = (m_time / 60) % 60; s = m_time % 60;
    if ((pi || fire) && !pm) begin
      if (old_mode == 1) m_time = ((h + 1) % 24) * 3600 + mi * 60 + s;
      if (old_mode == 2) m_time = h * 3600 + ((mi + 1) % 60) * 60 + s;
    end
    if (pm && old_mode == 2) m_time = m_time - (m_time % 60);
    if (pm || pi || fire) m_ticks = 0;
    else if (ts) m_ticks++;
    if (pm) m_mode = (old_mode + 1) % 3;
    m_prev_mode = bm;
    m_prev_inc = bi;
  endtask

  always @(negedge clkIn) begin
    if (check_en) begin
      check_value("mode", int'(mode), m_mode);
      check_value("divEn", int'(divEn), int'(m_mode == 0));
      check_value("hours", int'(hours), m_time / 3600);
      check_value("minutes", int'(minutes), (m_time / 60) % 60);
      check_value("seconds", int'(seconds), m_time % 60);
      check_value("dayWrap", int'(dayWrap), int'(m_day));
      check_value("blankHour", int'(blankHour), int'(m_mode == 1 && ((m_ticks / BLINK) % 2) == 1));
      check_value("blankMin", int'(blankMin), int'(m_mode == 2 && ((m_ticks / BLINK) % 2) == 1));
    end
  end

  task automatic apply_stimulus(bit rst_n, bit bm, bit bi, bit t1, bit ts);
    rstN = rst_n; btnMode = bm; btnInc = bi; tick1Hz = t1; tickSlow = ts;
    @(posedge clkIn);
    model_update(rst_n, bm, bi, t1, ts);
    @(negedge clkIn);
  endtask

  task automatic press_mode_btn();
    apply_stimulus(1, 1, 0, 0, 0);
    apply_stimulus(1, 0, 0, 0, 0);
  endtask

  task automatic press_inc_btn(int n);
    for (int i = 0; i < n; i++) begin
      apply_stimulus(1, 0, 1, 0, 0);
      apply_stimulus(1, 0, 0, 0, 0);
    end
  endtask

  task automatic run_ticks(int n, bit t1, bit ts);
    for (int i = 0; i < n; i++) apply_stimulus(1, 0, 0, t1, ts);
  endtask

  initial begin
    bit rbm, rbi;
    // Reset with both buttons held: no edges afterwards
    apply_stimulus(0, 1, 1, 0, 0);
    check_en = 1'b1;
    apply_stimulus(0, 1, 1, 1, 1);
    apply_stimulus(1, 1, 1, 0, 0);
    apply_stimulus(1, 1, 1, 0, 0);
    check_value("lit_reset_mode", int'(mode), 0);
    check_value("lit_reset_divEn", int'(divEn), 1);
    check_value("lit_reset_hours", int'(hours), 0);
    apply_stimulus(1, 0, 0, 0, 0);

    // Preload 23:59:58 and roll over the day
    press_mode_btn();
    press_inc_btn(23);
    press_mode_btn();
    press_inc_btn(59);
    press_mode_btn();
    run_ticks(58, 1, 0);
    run_ticks(1, 1, 0);
    check_value("lit_pre_hours", int'(hours), 23);
    check_value("lit_pre_seconds", int'(seconds), 59);
    check_value("lit_pre_dayWrap", int'(dayWrap), 0);
    run_ticks(1, 1, 0);
    check_value("lit_wrap_hours", int'(hours), 0);
    check_value("lit_wrap_minutes", int'(minutes), 0);
    check_value("lit_wrap_dayWrap", int'(dayWrap), 1);
    run_ticks(1, 0, 0);
    check_value("lit_wrap_pulse", int'(dayWrap), 0);
    run_ticks(5, 1, 0);

    // SET_HOUR: hour wraps at 23, tick1Hz ignored
    press_mode_btn();
    check_value("lit_sethour_mode", int'(mode), 1);
    check_value("lit_sethour_divEn", int'(divEn), 0);
    press_inc_btn(25);
    check_value("lit_sethour_hours", int'(hours), 1);
    run_ticks(5, 1, 0);
    check_value("lit_sethour_seconds", int'(seconds), 5);

    // SET_MIN: minute wraps without carry, leaving clears seconds
    press_mode_btn();
    press_inc_btn(59);
    check_value("lit_setmin_59", int'(minutes), 59);
    press_inc_btn(1);
    check_value("lit_setmin_wrap", int'(minutes), 0);
    check_value("lit_setmin_hours", int'(hours), 1);
    press_mode_btn();
    check_value("lit_run_mode", int'(mode), 0);
    check_value("lit_run_seconds", int'(seconds), 0);

    // Blink in SET_HOUR
    press_mode_btn();
    run_ticks(49, 0, 1);
    check_value("lit_blink_49", int'(blankHour), 0);
    run_ticks(1, 0, 1);
    check_value("lit_blink_50", int'(blankHour), 1);
    check_value("lit_blink_min", int'(blankMin), 0);
    run_ticks(50, 0, 1);
    check_value("lit_blink_100", int'(blankHour), 0);
    run_ticks(50, 0, 1);
    check_value("lit_blink_150", int'(blankHour), 1);
    apply_stimulus(1, 0, 1, 0, 0);
    check_value("lit_blink_inc", int'(blankHour), 0);
    check_value("lit_blink_hours", int'(hours), 2);
    apply_stimulus(1, 0, 0, 0, 0);

    // Simultaneous mode and increment presses
    apply_stimulus(1, 1, 1, 0, 0);
    check_value("lit_both_mode", int'(mode), 2);
    check_value("lit_both_hours", int'(hours), 2);
    apply_stimulus(1, 0, 0, 0, 0);

`ifdef AUTO_REPEAT_EN
    apply_stimulus(1, 0, 1, 0, 0);
    for (int i = 0; i < 70; i++) apply_stimulus(1, 0, 1, 0, 1);
    check_value("lit_repeat_minutes", int'(minutes), 4);
    apply_stimulus(1, 0, 0, 0, 0);
`endif

    // Randomized traffic including occasional mid-operation resets
    rbm = 0; rbi = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 59) == 0) rbm = ~rbm;
      if ($urandom_range(0, 29) == 0) rbi = ~rbi;
      apply_stimulus($urandom_range(0, 399) != 0, rbm, rbi,
                     $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 0);
    end

    check_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
